// File: rtl/puzzle_pkg.sv
// Shared types and BCD helper for the password puzzle game logic.
package puzzle_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, NEXT, WON, LOST} game_state_t;

  typedef logic [3:0] bcd_digit_t;

  // Two-digit BCD of a seconds value; callers keep sec <= 99.
  function automatic logic [7:0] to_bcd2(input logic [6:0] sec);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = 4'(sec / 7'd10);
    ones = 4'(sec % 7'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Game controller bundle: button/keypad/timer inputs and timer/status outputs.
interface round_sequencer_if;
  import puzzle_pkg::*;

  logic       start;
  logic       guess_valid;
  logic       guess_correct;
  logic       timer_expired;
  bcd_digit_t time_left;
  bcd_digit_t time_right;
  logic       timer_reload;
  logic       new_password;
  logic [2:0] round;
  logic [1:0] lives;
  logic       game_won;
  logic       game_lost;

  modport master (
    output start, guess_valid, guess_correct, timer_expired,
    input  time_left, time_right, timer_reload, new_password,
    input  round, lives, game_won, game_lost
  );

  modport slave (
    input  start, guess_valid, guess_correct, timer_expired,
    output time_left, time_right, timer_reload, new_password,
    output round, lives, game_won, game_lost
  );

endinterface

// File: rtl/round_sequencer.sv
// Round/lives controller for the password puzzle; loads per-round BCD time into the
// countdown timer, holds it in reload outside ARM/RUN, and declares win or loss.
module round_sequencer
  import puzzle_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 4,
  parameter int unsigned MAX_LIVES  = 3,
  parameter int unsigned START_SEC  = 30,
  parameter int unsigned STEP_SEC   = 5,
  parameter int unsigned MIN_SEC    = 10
) (
  input logic              clk,
  input logic              reset,
  round_sequencer_if.slave ctl
);

  localparam logic [2:0] LAST_ROUND = 3'(NUM_ROUNDS - 1);
  localparam logic [1:0] FULL_LIVES = 2'(MAX_LIVES);
  localparam logic [7:0] START8     = 8'(START_SEC);
  localparam logic [7:0] STEP8      = 8'(STEP_SEC);
  localparam logic [7:0] MIN8       = 8'(MIN_SEC);
  localparam logic [7:0] START_BCD  = to_bcd2(7'(START_SEC));

  // Clamp is decided before the subtraction so the 8-bit result never wraps.
  function automatic logic [6:0] round_sec(input logic [2:0] r);
    logic [7:0] step_total;
    step_total = STEP8 * {5'd0, r};
    if (START8 <= MIN8 || step_total >= START8 - MIN8) return 7'(MIN8);
    return 7'(START8 - step_total);
  endfunction

  game_state_t state, state_nxt;
  logic [2:0]  round_q, round_nxt;
  logic [1:0]  lives_q, lives_nxt;
  bcd_digit_t  tl_q, tr_q;
  logic        load_en;
  logic [7:0]  bcd_nxt;

  assign bcd_nxt = to_bcd2(round_sec(round_nxt));

  always_comb begin
    state_nxt = state;
    round_nxt = round_q;
    lives_nxt = lives_q;
    load_en   = 1'b0;
    case (state)
      IDLE, WON, LOST: begin
        if (ctl.start) begin
          state_nxt = LOAD;
          round_nxt = 3'd0;
          lives_nxt = FULL_LIVES;
          load_en   = 1'b1;
        end
      end
      LOAD: state_nxt = ARM;
      ARM:  state_nxt = RUN;
      RUN: begin
        if (ctl.guess_valid && ctl.guess_correct) begin
          state_nxt = NEXT;
        end else if (ctl.guess_valid) begin
          if (lives_q != 2'd0) lives_nxt = lives_q - 2'd1;
          if (lives_q <= 2'd1) state_nxt = LOST;
        end else if (ctl.timer_expired) begin
          state_nxt = LOST;
        end
      end
      NEXT: begin
        if (round_q == LAST_ROUND) begin
          state_nxt = WON;
        end else begin
          state_nxt = LOAD;
          round_nxt = round_q + 3'd1;
          load_en   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      round_q <= 3'd0;
      lives_q <= FULL_LIVES;
      tl_q    <= START_BCD[7:4];
      tr_q    <= START_BCD[3:0];
    end else begin
      state   <= state_nxt;
      round_q <= round_nxt;
      lives_q <= lives_nxt;
      if (load_en) begin
        tl_q <= bcd_nxt[7:4];
        tr_q <= bcd_nxt[3:0];
      end
    end
  end

  assign ctl.time_left    = tl_q;
  assign ctl.time_right   = tr_q;
  assign ctl.timer_reload = (state != ARM) && (state != RUN);
  assign ctl.new_password = (state == LOAD);
  assign ctl.round        = round_q;
  assign ctl.lives        = lives_q;
  assign ctl.game_won     = (state == WON);
  assign ctl.game_lost    = (state == LOST);

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: default game plus a steep-step instance for the time floor.
module tb_round_sequencer;

  typedef struct packed {
    logic [2:0] round;
    logic [3:0] tl;
    logic [3:0] tr;
  } ld_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  ld_t  q0[$];
  ld_t  q1[$];
  ld_t  e0, e1;

  always #5 clk = ~clk;

  round_sequencer_if m_if ();
  round_sequencer_if c_if ();

  round_sequencer u_dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (m_if)
  );

  round_sequencer #(
    .NUM_ROUNDS(4), .MAX_LIVES(3), .START_SEC(30), .STEP_SEC(10), .MIN_SEC(10)
  ) u_clamp (
    .clk   (clk),
    .reset (reset),
    .ctl   (c_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tb_sec(input bit w, input int r);
    int step;
    int s;
    step = w ? 10 : 5;
    s = 30 - step * r;
    if (s < 10) s = 10;
    return s;
  endfunction

  task automatic expect_load(input bit w, input int r);
    ld_t e;
    int  s;
    s = tb_sec(w, r);
    e.round = 3'(r);
    e.tl    = 4'(s / 10);
    e.tr    = 4'(s % 10);
    if (w) q1.push_back(e);
    else   q0.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w, input logic s, input logic gv, input logic gc, input logic te);
    if (w) begin
      c_if.start = s; c_if.guess_valid = gv; c_if.guess_correct = gc; c_if.timer_expired = te;
    end else begin
      m_if.start = s; m_if.guess_valid = gv; m_if.guess_correct = gc; m_if.timer_expired = te;
    end
  endtask

  // Inputs held across exactly one rising edge.
  task automatic pulse(input bit w, input logic s, input logic gv, input logic gc, input logic te);
    drive(w, s, gv, gc, te);
    tick();
    drive(w, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (m_if.new_password === 1'b1) begin
      if (q0.size() == 0) begin
        check("np_spurious_main", 32'(m_if.new_password), 0);
      end else begin
        e0 = q0.pop_front();
        check("sb_round_main", 32'(m_if.round), 32'(e0.round));
        check("sb_tl_main", 32'(m_if.time_left), 32'(e0.tl));
        check("sb_tr_main", 32'(m_if.time_right), 32'(e0.tr));
      end
    end
  end

  always @(negedge clk) begin
    if (c_if.new_password === 1'b1) begin
      if (q1.size() == 0) begin
        check("np_spurious_clamp", 32'(c_if.new_password), 0);
      end else begin
        e1 = q1.pop_front();
        check("sb_round_clamp", 32'(c_if.round), 32'(e1.round));
        check("sb_tl_clamp", 32'(c_if.time_left), 32'(e1.tl));
        check("sb_tr_clamp", 32'(c_if.time_right), 32'(e1.tr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    check("rst_round", 32'(m_if.round), 0);
    check("rst_lives", 32'(m_if.lives), 3);
    check("rst_reload", 32'(m_if.timer_reload), 1);
    check("rst_np", 32'(m_if.new_password), 0);
    check("rst_won", 32'(m_if.game_won), 0);
    check("rst_lost", 32'(m_if.game_lost), 0);
    check("rst_tl", 32'(m_if.time_left), 3);
    check("rst_tr", 32'(m_if.time_right), 0);
    reset = 1'b0;
    tick();
    check("idle_reload", 32'(m_if.timer_reload), 1);

    // Game 1: start latency, ARM ignores expiry, four correct rounds to a win.
    expect_load(1'b0, 0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("load_np", 32'(m_if.new_password), 1);
    check("load_reload", 32'(m_if.timer_reload), 1);
    tick();
    check("arm_reload", 32'(m_if.timer_reload), 0);
    check("arm_np", 32'(m_if.new_password), 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("run_reload", 32'(m_if.timer_reload), 0);
    check("run_lost_arm_exp", 32'(m_if.game_lost), 0);
    for (int r = 0; r < 4; r++) begin
      if (r < 3) expect_load(1'b0, r + 1);
      pulse(1'b0, 1'b0, 1'b1, 1'b1, (r == 0) ? 1'b1 : 1'b0);
      check("next_reload", 32'(m_if.timer_reload), 1);
      check("next_lost", 32'(m_if.game_lost), 0);
      if (r == 1) pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      else tick();
      if (r < 3) begin
        check("next_round", 32'(m_if.round), 32'(r + 1));
        tick();
        tick();
      end
    end
    check("won_flag", 32'(m_if.game_won), 1);
    check("won_round", 32'(m_if.round), 3);
    check("won_reload", 32'(m_if.timer_reload), 1);
    tick();
    tick();
    check("won_hold", 32'(m_if.game_won), 1);
    check("won_round_hold", 32'(m_if.round), 3);

    // Game 2: wrong guesses drain lives; extra guesses after loss are ignored.
    expect_load(1'b0, 0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("g2_won_clear", 32'(m_if.game_won), 0);
    check("g2_lives", 32'(m_if.lives), 3);
    check("g2_round", 32'(m_if.round), 0);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("wrong_lives", 32'(m_if.lives), 32'(2 - i));
      check("wrong_lost", 32'(m_if.game_lost), (i == 2) ? 1 : 0);
    end
    check("lost_reload", 32'(m_if.timer_reload), 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("lives_floor", 32'(m_if.lives), 0);
    check("lost_hold", 32'(m_if.game_lost), 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("lost_hold_correct", 32'(m_if.game_lost), 1);

    // Game 3: asynchronous reset in RUN at round 2.
    expect_load(1'b0, 0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    for (int r = 0; r < 2; r++) begin
      expect_load(1'b0, r + 1);
      pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      tick();
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("mid_lives", 32'(m_if.lives), 2);
    check("mid_round", 32'(m_if.round), 2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_round", 32'(m_if.round), 0);
    check("arst_lives", 32'(m_if.lives), 3);
    check("arst_reload", 32'(m_if.timer_reload), 1);
    check("arst_tl", 32'(m_if.time_left), 3);
    check("arst_tr", 32'(m_if.time_right), 0);
    check("arst_np", 32'(m_if.new_password), 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_reload", 32'(m_if.timer_reload), 1);

    // Game 4: timer expiry in RUN loses without costing a life.
    expect_load(1'b0, 0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("g4_run_lost", 32'(m_if.game_lost), 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("exp_lost", 32'(m_if.game_lost), 1);
    check("exp_lives", 32'(m_if.lives), 3);

    // Steep step: round 3 would be 0 s, floor holds it at 10 s.
    expect_load(1'b1, 0);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    for (int r = 0; r < 3; r++) begin
      expect_load(1'b1, r + 1);
      pulse(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      if (r == 2) begin
        check("clamp_round", 32'(c_if.round), 3);
        check("clamp_tl", 32'(c_if.time_left), 1);
        check("clamp_tr", 32'(c_if.time_right), 0);
      end
      tick();
      tick();
    end

    tick();
    check("sb_drain_main", 32'(q0.size()), 0);
    check("sb_drain_clamp", 32'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
